// File: rtl/layernorm_pack_tx.sv
// layernorm_pack_tx: gathers LANE-wide beats into the packed data/w/b operand
// buses of a layernorm array, fires the active-low operand strobes for one
// cycle once all three operands are full, then waits for the array's
// active-low completion before accepting the next load.
// Optional feature: define LAYERNORM_WB_PERSIST_EN to keep w and b loaded
// across runs so that only the data operand is reloaded after completion.
module layernorm_pack_tx #(
  parameter int unsigned INPUT_WIDTH  = 8,
  parameter int unsigned INPUT_NUM    = 768,
  parameter int unsigned SENTENCE_NUM = 128,
  parameter int unsigned LANE         = 16
) (
  input  logic                                         clk_p,
  input  logic                                         rst_p,
  input  logic [INPUT_WIDTH*LANE-1:0]                  s_data,
  input  logic [1:0]                                   s_kind,
  input  logic                                         s_valid,
  output logic                                         s_ready,
  output logic [INPUT_WIDTH*SENTENCE_NUM*INPUT_NUM-1:0] data,
  output logic [INPUT_WIDTH*SENTENCE_NUM*INPUT_NUM-1:0] w,
  output logic [INPUT_WIDTH*SENTENCE_NUM*INPUT_NUM-1:0] b,
  output logic                                         data_valid_n,
  output logic                                         w_valid_n,
  output logic                                         b_valid_n,
  input  logic                                         result_valid_n,
  output logic                                         busy,
  output logic                                         err_kind
);

  localparam int unsigned BEAT_W = INPUT_WIDTH * LANE;
  localparam int unsigned BEATS  = SENTENCE_NUM * INPUT_NUM / LANE;
  localparam int unsigned CW     = $clog2(BEATS + 1);

  localparam logic [1:0] LOAD = 2'd0;
  localparam logic [1:0] FIRE = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt_d, cnt_w, cnt_b;
  logic          full_d, full_w, full_b;
  logic          acc, acc_d, acc_w, acc_b;
  logic          fill_d, fill_w, fill_b;

  // Full flags, handshake decode and "full after this edge" lookahead
  always_comb begin
    full_d = (cnt_d == CW'(BEATS));
    full_w = (cnt_w == CW'(BEATS));
    full_b = (cnt_b == CW'(BEATS));
    s_ready = 1'b0;
    if (state == LOAD) begin
      case (s_kind)
        2'd0:    s_ready = !full_d;
        2'd1:    s_ready = !full_w;
        2'd2:    s_ready = !full_b;
        default: s_ready = 1'b1;
      endcase
    end
    acc    = s_valid && s_ready;
    acc_d  = acc && (s_kind == 2'd0);
    acc_w  = acc && (s_kind == 2'd1);
    acc_b  = acc && (s_kind == 2'd2);
    // Lets the last beat of the last operand move straight to FIRE
    fill_d = full_d || (acc_d && (cnt_d == CW'(BEATS - 1)));
    fill_w = full_w || (acc_w && (cnt_w == CW'(BEATS - 1)));
    fill_b = full_b || (acc_b && (cnt_b == CW'(BEATS - 1)));
  end

  // Strobes and busy decode straight from the state register
  always_comb begin
    data_valid_n = (state != FIRE);
    w_valid_n    = (state != FIRE);
    b_valid_n    = (state != FIRE);
    busy         = (state != LOAD);
  end

  // Control state, beat counters and sticky error flag
  always_ff @(posedge clk_p) begin
    if (rst_p) begin
      state    <= LOAD;
      cnt_d    <= '0;
      cnt_w    <= '0;
      cnt_b    <= '0;
      err_kind <= 1'b0;
    end else begin
      if (acc_d) cnt_d <= cnt_d + CW'(1);
      if (acc_w) cnt_w <= cnt_w + CW'(1);
      if (acc_b) cnt_b <= cnt_b + CW'(1);
      if (acc && (s_kind == 2'd3)) err_kind <= 1'b1;
      case (state)
        LOAD: if (fill_d && fill_w && fill_b) state <= FIRE;
        FIRE: state <= WAIT;
        WAIT: begin
          if (!result_valid_n) begin
            state <= LOAD;
            cnt_d <= '0;
`ifndef LAYERNORM_WB_PERSIST_EN
            cnt_w <= '0;
            cnt_b <= '0;
`endif
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  // Operand buffers; only writable in LOAD so they hold through FIRE/WAIT
  always_ff @(posedge clk_p) begin
    if (rst_p) begin
      data <= '0;
      w    <= '0;
      b    <= '0;
    end else begin
      for (int i = 0; i < int'(BEATS); i++) begin
        if (acc_d && (cnt_d == CW'(i))) data[i*BEAT_W +: BEAT_W] <= s_data;
        if (acc_w && (cnt_w == CW'(i))) w[i*BEAT_W +: BEAT_W]    <= s_data;
        if (acc_b && (cnt_b == CW'(i))) b[i*BEAT_W +: BEAT_W]    <= s_data;
      end
    end
  end

endmodule

// File: tb/tb_layernorm_pack_tx.sv
// Directed bench for layernorm_pack_tx with INPUT_NUM=4, SENTENCE_NUM=2,
// LANE=4, INPUT_WIDTH=8 (two 32-bit beats per 64-bit operand).
module tb_layernorm_pack_tx;

  logic        clk_p = 1'b0;
  logic        rst_p;
  logic [31:0] s_data;
  logic [1:0]  s_kind;
  logic        s_valid;
  logic        s_ready;
  logic [63:0] data, w, b;
  logic        data_valid_n, w_valid_n, b_valid_n;
  logic        result_valid_n;
  logic        busy, err_kind;

  int total = 0;
  int bad   = 0;

  layernorm_pack_tx #(
    .INPUT_WIDTH (8),
    .INPUT_NUM   (4),
    .SENTENCE_NUM(2),
    .LANE        (4)
  ) dut (
    .clk_p         (clk_p),
    .rst_p         (rst_p),
    .s_data        (s_data),
    .s_kind        (s_kind),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .data          (data),
    .w             (w),
    .b             (b),
    .data_valid_n  (data_valid_n),
    .w_valid_n     (w_valid_n),
    .b_valid_n     (b_valid_n),
    .result_valid_n(result_valid_n),
    .busy          (busy),
    .err_kind      (err_kind)
  );

  always #5 clk_p = ~clk_p;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just past it
  task automatic step();
    @(posedge clk_p);
    #1;
  endtask

  task automatic beat(input logic [1:0] kind, input logic [31:0] d);
    s_kind  = kind;
    s_data  = d;
    s_valid = 1'b1;
    #1;
    chk("beat_ready", {63'd0, s_ready}, 64'd1);
    step();
    s_valid = 1'b0;
  endtask

  function automatic logic [63:0] strobes();
    return {61'd0, data_valid_n, w_valid_n, b_valid_n};
  endfunction

  initial begin
    rst_p = 1'b1; s_data = '0; s_kind = 2'd0; s_valid = 1'b0; result_valid_n = 1'b1;
    step(); step();
    rst_p = 1'b0;
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_strobes", strobes(), 64'd7);
    chk("rst_data", data, 64'd0);
    chk("rst_w", w, 64'd0);
    chk("rst_err", {63'd0, err_kind}, 64'd0);

    // First run: data complete before w/b; third data beat must be refused
    beat(2'd0, 32'h04030201);
    beat(2'd0, 32'h08070605);
    s_kind = 2'd0; #1;
    chk("data_full_ready", {63'd0, s_ready}, 64'd0);
    s_kind = 2'd1; #1;
    chk("w_open_ready", {63'd0, s_ready}, 64'd1);
    beat(2'd1, 32'h11111111);
    beat(2'd2, 32'hAAAAAAAA);
    beat(2'd1, 32'h22222222);
    chk("prefire_strobes", strobes(), 64'd7);
    beat(2'd2, 32'hBBBBBBBB);
    chk("fire_strobes", strobes(), 64'd0);
    chk("fire_busy", {63'd0, busy}, 64'd1);
    chk("fire_data", data, 64'h0807060504030201);
    chk("fire_w", w, 64'h2222222211111111);
    chk("fire_b", b, 64'hBBBBBBBBAAAAAAAA);
    s_kind = 2'd3; #1;
    chk("fire_ready", {63'd0, s_ready}, 64'd0);
    // Completion during FIRE must be ignored
    result_valid_n = 1'b0;
    step();
    result_valid_n = 1'b1;
    chk("wait_strobes", strobes(), 64'd7);
    chk("wait_busy", {63'd0, busy}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("wait_hold_busy", {63'd0, busy}, 64'd1);
      chk("wait_hold_ready", {63'd0, s_ready}, 64'd0);
      chk("wait_hold_data", data, 64'h0807060504030201);
    end
    result_valid_n = 1'b0;
    step();
    result_valid_n = 1'b1;
    chk("done_busy", {63'd0, busy}, 64'd0);

    // Second run
    s_kind = 2'd1; #1;
`ifdef LAYERNORM_WB_PERSIST_EN
    chk("run2_w_ready", {63'd0, s_ready}, 64'd0);
    beat(2'd0, 32'h0C0B0A09);
    beat(2'd0, 32'h100F0E0D);
    chk("run2_strobes", strobes(), 64'd0);
    chk("run2_w", w, 64'h2222222211111111);
    chk("run2_b", b, 64'hBBBBBBBBAAAAAAAA);
`else
    chk("run2_w_ready", {63'd0, s_ready}, 64'd1);
    beat(2'd0, 32'h0C0B0A09);
    beat(2'd0, 32'h100F0E0D);
    chk("run2_nofire", strobes(), 64'd7);
    chk("run2_idle", {63'd0, busy}, 64'd0);
    beat(2'd1, 32'h33333333);
    beat(2'd1, 32'h44444444);
    beat(2'd2, 32'hCCCCCCCC);
    chk("run2_nofire_b", strobes(), 64'd7);
    beat(2'd2, 32'hDDDDDDDD);
    chk("run2_strobes", strobes(), 64'd0);
    chk("run2_w", w, 64'h4444444433333333);
    chk("run2_b", b, 64'hDDDDDDDDCCCCCCCC);
`endif
    chk("run2_data", data, 64'h100F0E0D0C0B0A09);
    // Fastest return: completion low from FIRE onward, LOAD two edges later
    result_valid_n = 1'b0;
    step();
    chk("run2_wait", {63'd0, busy}, 64'd1);
    step();
    result_valid_n = 1'b1;
    chk("run2_done", {63'd0, busy}, 64'd0);

    // Reserved kind: accepted, dropped, sticky error
    beat(2'd3, 32'hDEADBEEF);
    chk("k3_err", {63'd0, err_kind}, 64'd1);
    chk("k3_data", data, 64'h100F0E0D0C0B0A09);
    chk("k3_busy", {63'd0, busy}, 64'd0);
    step();
    chk("k3_err_hold", {63'd0, err_kind}, 64'd1);

    // Reset while in WAIT
    beat(2'd0, 32'h01010101);
    beat(2'd0, 32'h02020202);
`ifndef LAYERNORM_WB_PERSIST_EN
    beat(2'd1, 32'h55555555);
    beat(2'd1, 32'h66666666);
    beat(2'd2, 32'h77777777);
    beat(2'd2, 32'h88888888);
`endif
    chk("r_fire", strobes(), 64'd0);
    step();
    chk("r_wait", {63'd0, busy}, 64'd1);
    rst_p = 1'b1;
    step();
    rst_p = 1'b0;
    chk("r_busy", {63'd0, busy}, 64'd0);
    chk("r_data", data, 64'd0);
    chk("r_w", w, 64'd0);
    chk("r_b", b, 64'd0);
    chk("r_err", {63'd0, err_kind}, 64'd0);
    chk("r_strobes", strobes(), 64'd7);
    s_kind = 2'd1; #1;
    chk("r_w_ready", {63'd0, s_ready}, 64'd1);
    s_kind = 2'd0; #1;
    chk("r_d_ready", {63'd0, s_ready}, 64'd1);
    step(); step();
    chk("r_no_strobe", strobes(), 64'd7);
    chk("r_still_idle", {63'd0, busy}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
